cla_bist_checker: RTL and testbench
===================================

// Module: cla_bist_checker
// PURPOSE
//   Hardware self-test engine for the ALU's W-bit carry look-ahead adder.
//   Drives an exhaustive A/B/Cin sweep into the adder and checks the Sum/Cout it returns.
//   Counts mismatches and captures the first failing vector.
//   Sits beside the adder in TopLevel/ALU; the adder's operand inputs are muxed to it while busy.
// PARAMETERS
//   W       4  adder operand width; legal range 1..8
//   SETTLE  1  cycles to wait after driving a vector before sampling dut_sum/dut_cout; >=1
// PORTS
//   clk               in   1      rising-edge clock
//   rst               in   1      synchronous, active-high reset
//   start             in   1      1-cycle request to begin a sweep; honoured only in IDLE/DONE
//   dut_sum           in   W      Sum returned by the adder under test
//   dut_cout          in   1      Cout returned by the adder under test
//   op_a              out  W      operand A to the adder (registered)
//   op_b              out  W      operand B to the adder (registered)
//   op_cin            out  1      carry-in to the adder (registered)
//   busy              out  1      high from the cycle after start until the last check
//   done              out  1      high in DONE; held until the next start or rst
//   pass              out  1      done & (err_count==0); 0 whenever done=0
//   err_count         out  2W+2   mismatching vectors in the current/last sweep
//   first_fail_valid  out  1      a mismatch has been captured this sweep
//   first_fail_vec    out  2W+1   index {cin,a,b} of the first mismatch
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): state=IDLE; all outputs 0. Any sweep in progress is abandoned.
//   Vector index v = {op_cin, op_a, op_b}, 2W+1 bits.
//     v counts 0 .. 2^(2W+1)-1, so B is innermost, then A, with Cin outermost.
//   Expected result = {1'b0,a} + {1'b0,b} + cin, (W+1) bits; compared against {dut_cout,dut_sum}.
//   States:
//     IDLE  -> LOAD on start.
//     DONE  -> LOAD on start.
//     LOAD  (1 cycle): v<=0; drive op_*; err_count<=0; first_fail_valid<=0; busy=1; go WAIT.
//     WAIT  (SETTLE cycles, wait counter): hold op_*; go CHECK after the last one.
//     CHECK (1 cycle): sample the DUT and compare.
//           On mismatch: err_count++; if !first_fail_valid, capture v and set first_fail_valid.
//           If v==max: go DONE. Otherwise v<=v+1, drive the next op_*, and go WAIT.
//     DONE: busy=0, done=1; op_* hold the last vector; results held.
//   Cost: SETTLE+1 cycles per vector; sweep = 2^(2W+1)*(SETTLE+1) cycles + 1 LOAD cycle.
//     W=4, SETTLE=1: 1025 cycles from the start edge to done=1.
//   start while busy is ignored (no restart, no effect on counters).
//   start in DONE clears done/pass on the next edge and begins a new sweep.
//   err_count never overflows: its width holds the full vector count (2^(2W+1)).
//   v wrap-around never occurs; CHECK at v==max always exits to DONE.
//   rst overrides start when both are high in the same cycle.
//   Pure synchronous logic; no combinational path from dut_* to any output.
// TESTING (W=4, SETTLE=1, adder instantiated in the bench)
//   Correct adder model, start pulse:
//     -> done rises 1025 cycles later; pass=1; err_count=0; first_fail_valid=0.
//   dut_sum[0] forced 0:
//     -> err_count=256; first_fail_vec=9'h001 (a=0,b=1,cin=0); pass=0.
//   dut_cout forced 0:
//     -> err_count=256 (120 with cin=0, 136 with cin=1); first_fail_vec=9'h01F (a=1,b=15).
//   start pulsed again at cycle 300 of a sweep:
//     -> ignored; same 1025-cycle completion and results as the single-start run.
//   rst asserted mid-sweep (at v=100):
//     -> next cycle all outputs 0, IDLE; a subsequent start gives a clean full sweep.
//   Back-to-back: second start issued while in DONE:
//     -> done/pass drop next cycle; err_count restarts at 0.
//   Every run: monitor that op_* change only on the cycle after CHECK.

Source files
------------

// File: rtl/cla_bist_checker.sv
// Built-in self-test engine for a W-bit carry look-ahead adder: sweeps every
// {cin,a,b} vector, compares the adder's {cout,sum}, counts and captures failures.
module cla_bist_checker #(
    parameter int unsigned W      = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      dut_sum,
    input  logic              dut_cout,
    output logic [W-1:0]      op_a,
    output logic [W-1:0]      op_b,
    output logic              op_cin,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2*W+1:0]    err_count,
    output logic              first_fail_valid,
    output logic [2*W:0]      first_fail_vec
);

    localparam int unsigned VW = 2 * W + 1;
    localparam int unsigned EW = 2 * W + 2;
    localparam int unsigned SW = W + 1;
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state;
    logic [VW-1:0]   v;
    logic [CW-1:0]   wcnt;

    logic [SW-1:0]   exp_c;
    logic            mism_c;
    logic            last_c;

    // Operands are slices of the registered vector index, B innermost.
    assign op_b   = v[W-1:0];
    assign op_a   = v[2*W-1:W];
    assign op_cin = v[VW-1];

    assign exp_c  = SW'(op_a) + SW'(op_b) + SW'(op_cin);
    assign mism_c = ({dut_cout, dut_sum} != exp_c);
    assign last_c = (v == {VW{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            v                <= '0;
            wcnt             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                LOAD: begin
                    v                <= '0;
                    wcnt             <= '0;
                    err_count        <= '0;
                    first_fail_valid <= 1'b0;
                    first_fail_vec   <= '0;
                    state            <= WAIT;
                end
                WAIT: begin
                    if (wcnt == CW'(SETTLE - 1)) begin
                        wcnt  <= '0;
                        state <= CHECK;
                    end else begin
                        wcnt <= wcnt + CW'(1);
                    end
                end
                CHECK: begin
                    if (mism_c) begin
                        err_count <= err_count + EW'(1);
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= v;
                        end
                    end
                    // Final vector: results freeze, operands hold the last vector.
                    if (last_c) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !mism_c;
                    end else begin
                        v     <= v + VW'(1);
                        state <= WAIT;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_bist_checker.sv
// Self-checking bench for cla_bist_checker (W=4, SETTLE=1) with a fault-injectable adder.
module tb_cla_bist_checker;

    localparam int unsigned W    = 4;
    localparam int          NVEC = 512;
    localparam int          LAT  = 1025;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  dut_sum;
    logic        dut_cout;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic        op_cin;
    logic        busy;
    logic        done;
    logic        pass;
    logic [9:0]  err_count;
    logic        first_fail_valid;
    logic [8:0]  first_fail_vec;

    int errors = 0;
    int checks = 0;
    int mode   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    cla_bist_checker #(.W(W), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dut_sum(dut_sum), .dut_cout(dut_cout),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count),
        .first_fail_valid(first_fail_valid),
        .first_fail_vec(first_fail_vec)
    );

    // Adder under test: mode 1 forces sum[0]=0, mode 2 forces cout=0.
    logic [4:0] add_s;
    always_comb begin
        add_s = 5'(op_a) + 5'(op_b) + 5'(op_cin);
        if (mode == 1) add_s[0] = 1'b0;
        if (mode == 2) add_s[4] = 1'b0;
        dut_sum  = add_s[3:0];
        dut_cout = add_s[4];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Does vector j (= {cin,a,b}) disagree with true addition under fault mode m?
    function automatic bit vec_bad(input int j, input int m);
        int a, b, c, good, got;
        b = j % 16;
        a = (j / 16) % 16;
        c = j / 256;
        good = a + b + c;
        got  = good;
        if (m == 1) got = got - (good % 2);
        if (m == 2) got = good % 16;
        return got != good;
    endfunction

    // Model: k = clock edges since the accepted start, -1 when idle after reset.
    int       k = -1;
    int       run_mode = 0;
    int       e_vec, e_err, e_ffvec;
    bit       e_busy, e_done, e_pass, e_ffv;

    always @(posedge clk) begin
        if (rst) begin
            k = -1;
            e_vec = 0; e_err = 0; e_ffvec = 0;
            e_busy = 0; e_done = 0; e_pass = 0; e_ffv = 0;
        end else if (start && (k < 0 || k == LAT)) begin
            k = 0;
            run_mode = mode;
            e_busy = 1; e_done = 0; e_pass = 0;
        end else if (k >= 0 && k < LAT) begin
            int nchk;
            k++;
            e_vec = (k - 1) / 2;
            if (e_vec > NVEC - 1) e_vec = NVEC - 1;
            nchk = (k >= 3) ? (k - 3) / 2 + 1 : 0;
            if (nchk > NVEC) nchk = NVEC;
            e_err = 0; e_ffv = 0; e_ffvec = 0;
            for (int j = 0; j < nchk; j++) begin
                if (vec_bad(j, run_mode)) begin
                    e_err++;
                    if (!e_ffv) begin
                        e_ffv = 1;
                        e_ffvec = j;
                    end
                end
            end
            e_busy = (k < LAT);
            e_done = (k == LAT);
            e_pass = e_done && (e_err == 0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("op_vec", 32'({op_cin, op_a, op_b}), 32'(e_vec));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("pass", 32'(pass), 32'(e_pass));
            chk("err_count", 32'(err_count), 32'(e_err));
            chk("ff_valid", 32'(first_fail_valid), 32'(e_ffv));
            chk("ff_vec", 32'(first_fail_vec), 32'(e_ffvec));
        end
    end

    task automatic wait_done(input int extra_at, output int lat);
        lat = 0;
        while (!done && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            start = (lat == extra_at);
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 32'(lat), 32'(LAT));
    endtask

    task automatic run_sweep(input int m, input int extra_at, output int lat);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(extra_at, lat);
    endtask

    int lat;
    int guard;

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_over_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);

        // Correct adder.
        run_sweep(0, 0, lat);
        chk("lat_good", 32'(lat), 32'd1025);
        chk("pass_good", 32'(pass), 32'd1);
        chk("err_good", 32'(err_count), 32'd0);
        chk("ffv_good", 32'(first_fail_valid), 32'd0);

        // sum[0] stuck at 0.
        run_sweep(1, 0, lat);
        chk("lat_sum0", 32'(lat), 32'd1025);
        chk("err_sum0", 32'(err_count), 32'd256);
        chk("ffvec_sum0", 32'(first_fail_vec), 32'h001);
        chk("pass_sum0", 32'(pass), 32'd0);

        // cout stuck at 0.
        run_sweep(2, 0, lat);
        chk("err_cout", 32'(err_count), 32'd256);
        chk("ffvec_cout", 32'(first_fail_vec), 32'h01F);
        chk("ffv_cout", 32'(first_fail_valid), 32'd1);

        // Extra start mid-sweep is ignored.
        run_sweep(0, 300, lat);
        chk("lat_restart", 32'(lat), 32'd1025);
        chk("pass_restart", 32'(pass), 32'd1);

        // Back-to-back start from DONE after a failing sweep.
        run_sweep(1, 0, lat);
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_drop", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b_err_clear", 32'(err_count), 32'd0);
        wait_done(0, lat);
        chk("b2b_pass", 32'(pass), 32'd1);

        // Reset mid-sweep at v=100, then a clean sweep.
        @(negedge clk);
        mode  = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while ({op_cin, op_a, op_b} != 9'd100 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_v100", 32'({op_cin, op_a, op_b}), 32'd100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_ops", 32'({op_cin, op_a, op_b}), 32'd0);
        chk("rst_ffv", 32'(first_fail_valid), 32'd0);
        repeat (2) @(negedge clk);
        run_sweep(0, 0, lat);
        chk("lat_after_rst", 32'(lat), 32'd1025);
        chk("pass_after_rst", 32'(pass), 32'd1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
